axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI4-lite initiator; converts a simple valid/ready command/response interface into AXI4-lite write or read transactions.
- Sits between the PS-side test sequencers or soft controllers and AXI4-lite slave peripherals (GCD, control-register blocks).
- Used to program and poll those peripherals from fabric logic.

Parameters:
- C_ADDR_WIDTH, 32, width of cmd_addr and m_axi_awaddr/araddr.
- C_TIMEOUT, 1024, cycles allowed per transaction phase before abort; used only with AXI_LITE_MASTER_TIMEOUT_EN.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle, command accepted on valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  C_ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout
- rsp_timeout  out  1  response is a timeout abort (tied 0 without macro)
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-lite master side; addr C_ADDR_WIDTH, data 32, strb 4, resp 2.

Behaviour:
- Reset is asynchronous and active-low on aresetn, single clock aclk.
- Reset values: all valids, bready, rready, and rsp_valid are 0; rsp_rdata, rsp_resp, and rsp_timeout are 0; state IDLE. cmd_ready = (state==IDLE), so it is 1 after reset.
- All m_axi outputs and rsp_* outputs are registered.
- FSM states: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP.
- IDLE:
  - On cmd_valid & cmd_write: latch addr/wdata/wstrb; next cycle awvalid=1 and wvalid=1; go to WADDR_DATA.
  - On cmd_valid & !cmd_write: latch addr; next cycle arvalid=1; go to RADDR.
- WADDR_DATA:
  - awvalid drops the cycle after its own handshake. wvalid drops the cycle after its own handshake. The two channels are independent and may complete in either order or the same cycle.
  - Once both handshakes are done, go to WRESP with bready=1 the next cycle.
  - The master must tolerate slaves that raise wready only after the AW handshake.
- WRESP: on bvalid&bready, capture bresp, set rsp_rdata=0, clear bready, go to RSP.
- RADDR: arvalid held until arready; then arvalid=0, rready=1, go to RDATA.
- RDATA: on rvalid&rready, capture rdata/rresp, clear rready, go to RSP.
- RSP: rsp_valid=1 and held stable until rsp_ready; then go to IDLE. cmd_ready rises the cycle after the rsp handshake.
- Best-case latency, zero-wait slave: write cmd accept → rsp_valid is 4 cycles; read is 4 cycles.
- Valids and addresses never change while valid is asserted and the handshake is pending.
- Non-OKAY bresp/rresp is passed through unchanged; there is no retry.
- aresetn asserted mid-transaction: immediate return to IDLE, all valids low; the in-flight command is lost with no response.

Optional Feature:
- Macro: AXI_LITE_MASTER_TIMEOUT_EN.
- With the macro: a per-phase counter is cleared on entry to WADDR_DATA, WRESP, RADDR, and RDATA. If the counter reaches C_TIMEOUT-1 without phase completion:
  - all m_axi valids and readies are deasserted;
  - rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0;
  - state goes to RSP.
  - This is a debug recovery only.
- Without the macro: no counter; the master waits indefinitely; rsp_timeout is tied 0.

Decomposition:
- Package axi_lite_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, RESP_TIMEOUT=2'b11, FSM state encoding.
- No sub-module; the timeout counter is inline.

Test Plan:
- Write addr 0x08 data 48, wstrb 0xF, zero-wait slave → one AW and one W handshake, bready pulse, rsp_valid 4 cycles after accept, rsp_resp=0, rsp_rdata=0.
- Slave delays wready until 3 cycles after the AW handshake → awvalid drops after its handshake, wvalid is held 3 more cycles, response is correct.
- Read 0x18 with slave returning 0x10 and holding rvalid 5 cycles late → arvalid drops after handshake, rready held, rsp_rdata=0x10, rsp_resp=0.
- rsp_ready held low 10 cycles → rsp_valid and rsp_rdata stable, cmd_ready=0 throughout, cmd_ready=1 the cycle after the handshake.
- Slave returns bresp=2'b10 → rsp_resp=2'b10. With AXI_LITE_MASTER_TIMEOUT_EN and C_TIMEOUT=16, slave never asserts arready → arvalid drops after 16 cycles, rsp_resp=2'b11, rsp_timeout=1.
- aresetn pulsed low during WRESP → all outputs return to reset values asynchronously; a new command is accepted after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite response codes and the initiator FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    // Reported when a phase is aborted by the watchdog; same code as DECERR.
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WADDR_DATA = 3'd1,
        ST_WRESP      = 3'd2,
        ST_RADDR      = 3'd3,
        ST_RDATA      = 3'd4,
        ST_RSP        = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-lite initiator bridging a cmd/rsp valid-ready port (optional AXI_LITE_MASTER_TIMEOUT_EN phase watchdog).
// Latency: 4 cycles cmd accept -> rsp_valid against a slave with registered readies; all AXI and rsp outputs are flops.
// Backpressure: cmd_ready only in IDLE; rsp held stable until rsp_ready; AXI valids held until their own handshake.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_TIMEOUT    = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]             cmd_wdata,
    input  logic [3:0]              cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    state_e                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    aw_hs, w_hs;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int              TW      = $clog2(C_TIMEOUT) + 1;
    localparam logic [TW-1:0]   TO_LAST = TW'(C_TIMEOUT - 1);
    logic [TW-1:0]              timer_q, timer_d;
    logic                       rsp_timeout_q, rsp_timeout_d;
    logic                       phase_active;
    logic                       abort;
`endif

    assign aw_hs = awvalid_q & m_axi_awready;
    assign w_hs  = wvalid_q & m_axi_wready;

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WADDR_DATA;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end
            end
            ST_WADDR_DATA: begin
                // AW and W retire independently; the phase ends once both have.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (m_axi_bvalid && bready_q) begin
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = ST_RSP;
                end
            end
            ST_RADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (m_axi_rvalid && rready_q) begin
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_valid_d = 1'b1;
                    rready_d    = 1'b0;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // Watchdog: counter restarts on every phase change and aborts a phase
        // that has not completed by its C_TIMEOUT-th cycle.
        timer_d       = timer_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;
        phase_active  = (state_q == ST_WADDR_DATA) || (state_q == ST_WRESP) ||
                        (state_q == ST_RADDR)      || (state_q == ST_RDATA);
        if (state_q == ST_IDLE && cmd_valid) begin
            rsp_timeout_d = 1'b0;
        end
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (phase_active) begin
            timer_d = timer_q + 1'b1;
            abort   = (timer_q == TO_LAST);
        end
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = RESP_TIMEOUT;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            timer_d       = '0;
            state_d       = ST_RSP;
        end
`endif
    end

    // State and output registers; reset drops every valid/ready immediately.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    // Watchdog counter and timeout flag registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            timer_q       <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboarded bench for axi_lite_master against a behavioural AXI4-lite slave with per-channel delays.
// Latency: expectations are hand-computed per directed vector.
// Backpressure: the response monitor owns rsp_ready and can hold it low for a set number of cycles.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW = 32;
    localparam int TO = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          cmd_ready, rsp_valid, rsp_timeout;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic          m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic [31:0]   m_axi_rdata = '0;

    axi_lite_master #(.C_ADDR_WIDTH(AW), .C_TIMEOUT(TO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        int          lat;
        int          hold;
    } exp_t;
    exp_t sb_q[$];

    function automatic exp_t mk_exp(input logic [31:0] rdata, input logic [1:0] resp,
                                    input logic to, input int lat, input int hold);
        exp_t e;
        e.rdata = rdata; e.resp = resp; e.to = to; e.lat = lat; e.hold = hold;
        return e;
    endfunction

    // Slave configuration and bookkeeping
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          ar_never = 0, b_never = 0, abort_ok = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = '0;
    int          aw_t = 0, w_t = 0, b_t = 0, ar_t = 0, r_t = 0;
    bit          aw_pend = 0, w_pend = 0, b_pend = 0, ar_pend = 0, r_pend = 0;
    bit          aw_done = 0, w_done = 0, ar_done = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0, bready_hi = 0, rready_hi = 0, rsp_hi = 0;
    int          stab_err = 0, rsp_stab_err = 0;

    // Behavioural slave: readies/responses change on the falling edge only.
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            aw_t = 0; w_t = 0; b_t = 0; ar_t = 0; r_t = 0;
            aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
            aw_done = 0; w_done = 0; ar_done = 0;
        end else begin
            if (aw_pend) begin aw_pend = 0; m_axi_awready = 0; aw_done = 1; aw_hs_n++; aw_t = 0; end
            if (!m_axi_awvalid) begin m_axi_awready = 0; aw_t = 0; end
            else if (!m_axi_awready) begin aw_t++; if (aw_t >= 2 + aw_dly) m_axi_awready = 1; end
            if (m_axi_awvalid && m_axi_awready) begin aw_pend = 1; cap_awaddr = m_axi_awaddr; end

            if (w_pend) begin w_pend = 0; m_axi_wready = 0; w_done = 1; w_hs_n++; w_t = 0; end
            if (!m_axi_wvalid) begin m_axi_wready = 0; w_t = 0; end
            else if (!m_axi_wready) begin w_t++; if (w_t >= 2 + w_dly) m_axi_wready = 1; end
            if (m_axi_wvalid && m_axi_wready) begin
                w_pend = 1; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
            end

            if (b_pend) begin b_pend = 0; m_axi_bvalid = 0; aw_done = 0; w_done = 0; b_hs_n++; b_t = 0; end
            else if (aw_done && w_done && !m_axi_bvalid && !b_never) begin
                b_t++;
                if (b_t >= 1 + b_dly) begin m_axi_bvalid = 1; m_axi_bresp = b_resp_cfg; end
            end
            if (m_axi_bvalid && m_axi_bready) b_pend = 1;

            if (ar_pend) begin ar_pend = 0; m_axi_arready = 0; ar_done = 1; ar_hs_n++; ar_t = 0; end
            if (!m_axi_arvalid) begin m_axi_arready = 0; ar_t = 0; end
            else if (!m_axi_arready && !ar_never) begin ar_t++; if (ar_t >= 2 + ar_dly) m_axi_arready = 1; end
            if (m_axi_arvalid && m_axi_arready) begin ar_pend = 1; cap_araddr = m_axi_araddr; end

            if (r_pend) begin r_pend = 0; m_axi_rvalid = 0; ar_done = 0; r_hs_n++; r_t = 0; end
            else if (ar_done && !m_axi_rvalid) begin
                r_t++;
                if (r_t >= 1 + r_dly) begin
                    m_axi_rvalid = 1; m_axi_rdata = r_data_cfg; m_axi_rresp = r_resp_cfg;
                end
            end
            if (m_axi_rvalid && m_axi_rready) r_pend = 1;
        end
    end

    // Channel monitor: activity counters and AXI valid/payload stability.
    logic          p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0;
    logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
    logic [31:0]   p_wdata = '0;
    logic [3:0]    p_wstrb = '0;
    always begin
        @(negedge aclk);
        #2;
        if (!aresetn) begin
            p_awv = 0; p_wv = 0; p_arv = 0; p_awhs = 0; p_whs = 0; p_arhs = 0;
        end else begin
            if (m_axi_awvalid) aw_hi++;
            if (m_axi_wvalid)  w_hi++;
            if (m_axi_arvalid) ar_hi++;
            if (m_axi_bready)  bready_hi++;
            if (m_axi_rready)  rready_hi++;
            if (rsp_valid)     rsp_hi++;
            if (p_awv && !p_awhs && (m_axi_awvalid ? (m_axi_awaddr !== p_awaddr) : !abort_ok)) stab_err++;
            if (p_wv && !p_whs && (m_axi_wvalid ? ({m_axi_wdata, m_axi_wstrb} !== {p_wdata, p_wstrb}) : !abort_ok)) stab_err++;
            if (p_arv && !p_arhs && (m_axi_arvalid ? (m_axi_araddr !== p_araddr) : !abort_ok)) stab_err++;
            p_awv = m_axi_awvalid; p_awhs = m_axi_awvalid && m_axi_awready; p_awaddr = m_axi_awaddr;
            p_wv  = m_axi_wvalid;  p_whs  = m_axi_wvalid && m_axi_wready;
            p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
            p_arv = m_axi_arvalid; p_arhs = m_axi_arvalid && m_axi_arready; p_araddr = m_axi_araddr;
        end
    end

    // Response monitor: pops the scoreboard whenever a response is taken.
    int          acc_edge = 0;
    int          rsp_done_n = 0;
    int          held = 0;
    bit          rsp_seen = 0, post_chk = 0;
    logic [31:0] snap_rdata = '0;
    logic [1:0]  snap_resp = '0;
    always begin
        @(negedge aclk);
        #2;
        rsp_ready = 1'b0;
        if (post_chk) begin
            post_chk = 0;
            check("cmd_ready_after_rsp", cmd_ready, 1'b1);
        end
        if (!aresetn) begin
            rsp_seen = 0;
        end else if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=0x%0h, expected no response", rsp_rdata);
                rsp_ready = 1'b1;
            end else begin
                if (!rsp_seen) begin
                    rsp_seen = 1; held = 0;
                    snap_rdata = rsp_rdata; snap_resp = rsp_resp;
                    if (sb_q[0].lat >= 0) check("rsp_latency", 64'((cyc + 1) - acc_edge), 64'(sb_q[0].lat));
                end else if (rsp_rdata !== snap_rdata || rsp_resp !== snap_resp || cmd_ready !== 1'b0) begin
                    rsp_stab_err++;
                end
                if (held >= sb_q[0].hold) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    rsp_ready = 1'b1;
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", rsp_resp, e.resp);
                    check("rsp_timeout", rsp_timeout, e.to);
                    rsp_seen = 0; post_chk = 1; rsp_done_n++;
                end else begin
                    held++;
                end
            end
        end
    end

    task automatic clr_stats();
        @(negedge aclk);
        aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
        aw_hi = 0; w_hi = 0; ar_hi = 0; bready_hi = 0; rready_hi = 0; rsp_hi = 0;
        rsp_stab_err = 0;
    endtask

    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input bit push, input exp_t e);
        int n;
        if (push) sb_q.push_back(e);
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        acc_edge = cyc + 1;
        if (n >= 50) check("cmd_accept_wait", 64'(n), 64'(0));
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_done_n < target && n < 300) begin @(negedge aclk); n++; end
        check("rsp_wait", 64'(rsp_done_n), 64'(target));
        repeat (2) @(negedge aclk);
    endtask

    // {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, awaddr}
    function automatic logic [73:0] rst_vec();
        return {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, m_axi_awaddr};
    endfunction
    localparam logic [73:0] RST_EXP = {1'b1, 73'd0};

    initial begin
        int exp_n;
        int n;
        exp_n = 0;
        #12;
        check("reset_outputs", rst_vec(), RST_EXP);
        @(negedge aclk); #3 aresetn = 1'b1;
        @(negedge aclk);
        check("cmd_ready_after_reset", cmd_ready, 1'b1);

        // Write 0x08 <- 48, zero-wait slave.
        clr_stats();
        do_cmd(1, 32'h08, 32'd48, 4'hF, 1, mk_exp(32'h0, RESP_OKAY, 1'b0, 4, 0));
        wait_rsp(++exp_n);
        check("wr_awaddr", cap_awaddr, 32'h08);
        check("wr_wdata", cap_wdata, 32'd48);
        check("wr_wstrb", cap_wstrb, 4'hF);
        check("wr_hs_counts", {8'(aw_hs_n), 8'(w_hs_n), 8'(b_hs_n)}, {8'd1, 8'd1, 8'd1});
        check("wr_bready_pulse", 64'(bready_hi), 64'd1);
        check("wr_awvalid_cycles", 64'(aw_hi), 64'd2);

        // wready three cycles after the AW handshake.
        clr_stats();
        w_dly = 3;
        do_cmd(1, 32'h0C, 32'hDEADBEEF, 4'h3, 1, mk_exp(32'h0, RESP_OKAY, 1'b0, 7, 0));
        wait_rsp(++exp_n);
        w_dly = 0;
        check("wlate_awvalid_cycles", 64'(aw_hi), 64'd2);
        check("wlate_wvalid_cycles", 64'(w_hi), 64'd5);
        check("wlate_wdata", {cap_wdata, cap_wstrb}, {32'hDEADBEEF, 4'h3});

        // Read 0x18, rvalid five cycles late.
        clr_stats();
        r_dly = 5; r_data_cfg = 32'h10;
        do_cmd(0, 32'h18, 32'h0, 4'h0, 1, mk_exp(32'h10, RESP_OKAY, 1'b0, 9, 0));
        wait_rsp(++exp_n);
        r_dly = 0;
        check("rd_araddr", cap_araddr, 32'h18);
        check("rd_arvalid_cycles", 64'(ar_hi), 64'd2);
        check("rd_rready_cycles", 64'(rready_hi), 64'd6);

        // rsp_ready held off for 10 cycles.
        clr_stats();
        r_data_cfg = 32'hA5A50001; r_resp_cfg = RESP_EXOKAY;
        do_cmd(0, 32'h20, 32'h0, 4'h0, 1, mk_exp(32'hA5A50001, RESP_EXOKAY, 1'b0, 4, 10));
        wait_rsp(++exp_n);
        r_resp_cfg = RESP_OKAY;
        check("hold_rsp_stable", 64'(rsp_stab_err), 64'd0);
        check("hold_rsp_valid_cycles", 64'(rsp_hi), 64'd11);

        // SLVERR write response passes through.
        clr_stats();
        b_resp_cfg = RESP_SLVERR;
        do_cmd(1, 32'h04, 32'h12345678, 4'h1, 1, mk_exp(32'h0, RESP_SLVERR, 1'b0, 4, 0));
        wait_rsp(++exp_n);
        b_resp_cfg = RESP_OKAY;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // arready never comes: watchdog aborts after TO cycles.
        clr_stats();
        ar_never = 1; abort_ok = 1;
        do_cmd(0, 32'h30, 32'h0, 4'h0, 1, mk_exp(32'h0, RESP_TIMEOUT, 1'b1, TO + 1, 0));
        wait_rsp(++exp_n);
        ar_never = 0; abort_ok = 0;
        check("to_arvalid_cycles", 64'(ar_hi), 64'(TO));
        check("to_ar_hs", 64'(ar_hs_n), 64'd0);
        clr_stats();
        r_data_cfg = 32'h0BADF00D;
        do_cmd(0, 32'h34, 32'h0, 4'h0, 1, mk_exp(32'h0BADF00D, RESP_OKAY, 1'b0, 4, 0));
        wait_rsp(++exp_n);
`endif

        // Reset while waiting for the write response.
        clr_stats();
        b_never = 1;
        do_cmd(1, 32'h40, 32'hCAFE0000, 4'hF, 0, mk_exp(32'h0, RESP_OKAY, 1'b0, -1, 0));
        n = 0;
        while (!m_axi_bready && n < 50) begin @(negedge aclk); n++; end
        check("reach_wresp", m_axi_bready, 1'b1);
        @(negedge aclk);
        #3 aresetn = 1'b0;
        #1 check("reset_async_outputs", rst_vec(), RST_EXP);
        @(negedge aclk);
        @(negedge aclk);
        b_never = 0;
        #3 aresetn = 1'b1;
        clr_stats();
        do_cmd(1, 32'h44, 32'h00C0FFEE, 4'hC, 1, mk_exp(32'h0, RESP_OKAY, 1'b0, 4, 0));
        wait_rsp(++exp_n);
        check("post_reset_wdata", {cap_awaddr, cap_wdata}, {32'h44, 32'h00C0FFEE});

        check("axi_stability", 64'(stab_err), 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
